// File: rtl/stats_counter_ram_if.sv
// Statistics increment stream plus read-only counter register port.
// master: stats collector / host side; slave: stats_counter_ram.
interface stats_counter_ram_if #(
    parameter int STAT_INC_WIDTH = 24,
    parameter int STAT_ID_WIDTH  = 5,
    parameter int REG_ADDR_WIDTH = 7,
    parameter int REG_DATA_WIDTH = 32
);
    logic [STAT_INC_WIDTH-1:0] s_axis_stat_tdata;
    logic [STAT_ID_WIDTH-1:0]  s_axis_stat_tid;
    logic                      s_axis_stat_tvalid;
    logic                      s_axis_stat_tready;
    logic [REG_ADDR_WIDTH-1:0] reg_rd_addr;
    logic                      reg_rd_en;
    logic [REG_DATA_WIDTH-1:0] reg_rd_data;
    logic                      reg_rd_wait;
    logic                      reg_rd_ack;

    modport master (
        output s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tvalid,
        input  s_axis_stat_tready,
        output reg_rd_addr, reg_rd_en,
        input  reg_rd_data, reg_rd_wait, reg_rd_ack
    );

    modport slave (
        input  s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tvalid,
        output s_axis_stat_tready,
        input  reg_rd_addr, reg_rd_en,
        output reg_rd_data, reg_rd_wait, reg_rd_ack
    );
endinterface

// File: rtl/stats_counter_ram.sv
// Statistics counter RAM: accumulates (tid, tdata) increments into
// counter[tid] and serves host reads of counter[addr[ID+1:2]].
// Ports: clk, rst (async, active-high), bus (stats_counter_ram_if.slave).
// Option: define STATS_COUNTER_SATURATE_EN to saturate at all-ones.
module stats_counter_ram #(
    parameter int STAT_INC_WIDTH   = 24,
    parameter int STAT_ID_WIDTH    = 5,
    parameter int STAT_COUNT_WIDTH = 32,
    parameter int REG_ADDR_WIDTH   = 7,
    parameter int REG_DATA_WIDTH   = 32
) (
    input logic clk,
    input logic rst,
    stats_counter_ram_if.slave bus
);
    localparam int DEPTH = 2 ** STAT_ID_WIDTH;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        UPD_RD,
        UPD_WR,
        RD_RD,
        RD_ACK
    } state_t;

    state_t                      state;
    logic [STAT_ID_WIDTH-1:0]    clr_ptr;
    logic [STAT_ID_WIDTH-1:0]    idx;
    logic [STAT_INC_WIDTH-1:0]   inc;
    logic                        last_reg;
    logic                        ack;
    logic [REG_DATA_WIDTH-1:0]   data;

    logic [STAT_COUNT_WIDTH-1:0] mem [DEPTH];
    logic [STAT_COUNT_WIDTH-1:0] q;
    logic [STAT_ID_WIDTH-1:0]    addr;
    logic [STAT_COUNT_WIDTH-1:0] wdata;
    logic [STAT_COUNT_WIDTH-1:0] new_val;
    logic                        we;
    logic                        re;

    logic [STAT_ID_WIDTH-1:0]    rd_idx;
    logic                        grant_stat;
    logic                        grant_reg;
    logic                        unused_addr;

    assign rd_idx      = bus.reg_rd_addr[STAT_ID_WIDTH+1:2];
    assign unused_addr = ^bus.reg_rd_addr;

    // Round-robin: on contention the requester not served last wins.
    assign grant_stat = (state == IDLE) && bus.s_axis_stat_tvalid &&
                        (!bus.reg_rd_en || last_reg);
    assign grant_reg  = (state == IDLE) && bus.reg_rd_en &&
                        (!bus.s_axis_stat_tvalid || !last_reg);

    // tready must coincide with the grant cycle, so it is decoded
    // directly from the IDLE arbitration rather than registered.
    assign bus.s_axis_stat_tready = grant_stat;
    assign bus.reg_rd_wait        = bus.reg_rd_en && !ack;
    assign bus.reg_rd_ack         = ack;
    assign bus.reg_rd_data        = data;

`ifdef STATS_COUNTER_SATURATE_EN
    logic [STAT_COUNT_WIDTH:0] sum;
    assign sum     = {1'b0, q} + (STAT_COUNT_WIDTH+1)'(inc);
    assign new_val = sum[STAT_COUNT_WIDTH] ? '1 : sum[STAT_COUNT_WIDTH-1:0];
`else
    assign new_val = q + STAT_COUNT_WIDTH'(inc);
`endif

    // Single RAM port: serialised FSM guarantees one access per cycle.
    always_comb begin
        addr = idx;
        if (state == INIT) begin
            addr = clr_ptr;
        end else if (grant_stat) begin
            addr = bus.s_axis_stat_tid;
        end else if (grant_reg) begin
            addr = rd_idx;
        end
    end

    assign we    = (state == INIT) || (state == UPD_WR);
    assign re    = grant_stat || grant_reg;
    assign wdata = (state == INIT) ? '0 : new_val;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            q <= mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            clr_ptr  <= '0;
            idx      <= '0;
            inc      <= '0;
            last_reg <= 1'b0;
            ack      <= 1'b0;
            data     <= '0;
        end else begin
            ack  <= 1'b0;
            data <= '0;
            unique case (state)
                INIT: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == '1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (grant_stat) begin
                        idx      <= bus.s_axis_stat_tid;
                        inc      <= bus.s_axis_stat_tdata;
                        last_reg <= 1'b0;
                        state    <= UPD_RD;
                    end else if (grant_reg) begin
                        idx      <= rd_idx;
                        last_reg <= 1'b1;
                        state    <= RD_RD;
                    end
                end
                UPD_RD: state <= UPD_WR;
                UPD_WR: state <= IDLE;
                RD_RD: begin
                    ack   <= 1'b1;
                    data  <= REG_DATA_WIDTH'(q);
                    state <= RD_ACK;
                end
                RD_ACK: state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_stats_counter_ram.sv
// Randomized self-checking bench for stats_counter_ram.
// Reference: plain array of counters updated by the increment rules.
module tb_stats_counter_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stats_counter_ram_if #(
        .STAT_INC_WIDTH(24),
        .STAT_ID_WIDTH(5),
        .REG_ADDR_WIDTH(7),
        .REG_DATA_WIDTH(32)
    ) bus ();

    stats_counter_ram #(
        .STAT_INC_WIDTH(24),
        .STAT_ID_WIDTH(5),
        .STAT_COUNT_WIDTH(32),
        .REG_ADDR_WIDTH(7),
        .REG_DATA_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int fails = 0;
    logic [31:0] model [32];

    function automatic logic [31:0] add_model(logic [31:0] a, logic [23:0] d);
        logic [63:0] s;
        s = {32'd0, a} + {40'd0, d};
`ifdef STATS_COUNTER_SATURATE_EN
        if (s > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
        return s[31:0];
    endfunction

    task automatic send_inc(input logic [4:0] t, input logic [23:0] d);
        int n;
        bus.s_axis_stat_tid = t;
        bus.s_axis_stat_tdata = d;
        bus.s_axis_stat_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_axis_stat_tready && n < 100);
        checks++;
        if (!bus.s_axis_stat_tready) begin
            fails++;
            $display("FAIL inc_timeout tid=%0d: tready=0 after %0d cycles, required 1", t, n);
        end else begin
            model[t] = add_model(model[t], d);
        end
        @(posedge clk);
        #1 bus.s_axis_stat_tvalid = 1'b0;
    endtask

    task automatic do_read(input logic [6:0] a, output logic [31:0] d, output int lat);
        bus.reg_rd_addr = a;
        bus.reg_rd_en = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.reg_rd_ack && lat < 100);
        checks++;
        if (!bus.reg_rd_ack) begin
            fails++;
            $display("FAIL read_timeout addr=%h: ack=0 after %0d cycles, required 1", a, lat);
        end
        d = bus.reg_rd_data;
        @(posedge clk);
        #1 bus.reg_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        int ack_n;
        bit tr_seen;
        logic [31:0] d;
        int lat;
        logic [6:0] a;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.s_axis_stat_tready !== 1'b0 || bus.reg_rd_ack !== 1'b0 ||
            bus.reg_rd_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: tready=%b ack=%b data=%h, required 0 0 0",
                     bus.s_axis_stat_tready, bus.reg_rd_ack, bus.reg_rd_data);
        end
        bus.s_axis_stat_tvalid = 1'b1;
        bus.s_axis_stat_tid = 5'd0;
        bus.s_axis_stat_tdata = 24'd0;
        bus.reg_rd_addr = 7'h48;
        bus.reg_rd_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        ack_n = 0;
        tr_seen = 0;
        while (ack_n == 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if (bus.reg_rd_wait !== 1'b1) begin
                    fails++;
                    $display("FAIL init_wait: wait=%b, required 1", bus.reg_rd_wait);
                end
            end
            if (n <= 32 && bus.s_axis_stat_tready) tr_seen = 1;
            if (bus.reg_rd_ack) ack_n = n;
        end
        checks++;
        if (tr_seen) begin
            fails++;
            $display("FAIL init_tready: tready=1 during INIT, required 0");
        end
        checks++;
        if (ack_n != 35) begin
            fails++;
            $display("FAIL init_ack_cycle: first ack at cycle %0d, required 35", ack_n);
        end
        checks++;
        if (bus.reg_rd_data !== 32'd0) begin
            fails++;
            $display("FAIL init_read18: data=%h, required 0", bus.reg_rd_data);
        end
        @(posedge clk);
        #1 bus.reg_rd_en = 1'b0;
        send_inc(5'd0, 24'd0);
        for (int i = 0; i < 32; i++) begin
            a = {i[4:0], 2'b00};
            do_read(a, d, lat);
            checks++;
            if (d !== 32'd0) begin
                fails++;
                $display("FAIL init_clear idx=%0d: data=%h, required 0", i, d);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        int lat;
        send_inc(5'd3, 24'd5);
        send_inc(5'd3, 24'd7);
        repeat (3) @(posedge clk);
        #1;
        do_read(7'h0C, d, lat);
        checks++;
        if (d !== 32'd12) begin
            fails++;
            $display("FAIL basic_sum: data=%0d, required 12", d);
        end
        checks++;
        if (lat != 3) begin
            fails++;
            $display("FAIL basic_latency: ack at cycle %0d, required 3", lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        int lat;
        logic [6:0] a;
        logic [23:0] v;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = 7'($urandom);
                do_read(a, d, lat);
                checks++;
                if (d !== model[a[6:2]]) begin
                    fails++;
                    $display("FAIL random_read addr=%h: data=%h, required %h",
                             a, d, model[a[6:2]]);
                end
            end else begin
                v = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
                send_inc(5'($urandom), v);
            end
        end
    endtask

    task automatic test_back_to_back();
        int last_t;
        int last_a;
        int nt;
        int na;
        logic [4:0] ridx;
        logic [4:0] t;
        logic [23:0] v;
        bit took;
        bit acked;
        last_t = -1;
        last_a = -1;
        nt = 0;
        na = 0;
        t = 5'($urandom_range(0, 3));
        v = 24'($urandom);
        ridx = 5'($urandom_range(0, 3));
        bus.s_axis_stat_tid = t;
        bus.s_axis_stat_tdata = v;
        bus.s_axis_stat_tvalid = 1'b1;
        bus.reg_rd_addr = {ridx, 2'($urandom)};
        bus.reg_rd_en = 1'b1;
        for (int c = 0; c < 72; c++) begin
            @(negedge clk);
            took = bus.s_axis_stat_tready;
            acked = bus.reg_rd_ack;
            if (took) begin
                model[t] = add_model(model[t], v);
                if (last_t >= 0) begin
                    checks++;
                    if (c - last_t != 6) begin
                        fails++;
                        $display("FAIL b2b_tready_gap: gap=%0d, required 6", c - last_t);
                    end
                end
                last_t = c;
                nt++;
            end
            if (acked) begin
                checks++;
                if (bus.reg_rd_data !== model[ridx]) begin
                    fails++;
                    $display("FAIL b2b_read idx=%0d: data=%h, required %h",
                             ridx, bus.reg_rd_data, model[ridx]);
                end
                if (last_a >= 0) begin
                    checks++;
                    if (c - last_a > 6) begin
                        fails++;
                        $display("FAIL b2b_ack_gap: gap=%0d, required <=6", c - last_a);
                    end
                end
                last_a = c;
                na++;
            end
            @(posedge clk);
            #1;
            if (took) begin
                t = 5'($urandom_range(0, 3));
                v = 24'($urandom);
                bus.s_axis_stat_tid = t;
                bus.s_axis_stat_tdata = v;
            end
            if (acked) begin
                ridx = 5'($urandom_range(0, 3));
                bus.reg_rd_addr = {ridx, 2'($urandom)};
            end
        end
        bus.s_axis_stat_tvalid = 1'b0;
        bus.reg_rd_en = 1'b0;
        checks++;
        if (nt < 10 || na < 10 || nt - na > 1 || na - nt > 1) begin
            fails++;
            $display("FAIL b2b_fairness: incs=%0d reads=%0d, required equal within 1",
                     nt, na);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        int n;
        int ack_n;
        logic [31:0] d;
        int lat;
        bus.s_axis_stat_tid = 5'd2;
        bus.s_axis_stat_tdata = 24'd9;
        bus.s_axis_stat_tvalid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_axis_stat_tready && n < 100);
        @(posedge clk);
        #1 bus.s_axis_stat_tvalid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(negedge clk);
        checks++;
        if (bus.reg_rd_ack !== 1'b0 || bus.s_axis_stat_tready !== 1'b0) begin
            fails++;
            $display("FAIL midop_reset_out: ack=%b tready=%b, required 0 0",
                     bus.reg_rd_ack, bus.s_axis_stat_tready);
        end
        bus.reg_rd_addr = 7'h08;
        bus.reg_rd_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        ack_n = 0;
        while (ack_n == 0 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.reg_rd_ack) ack_n = n;
        end
        checks++;
        if (ack_n != 35) begin
            fails++;
            $display("FAIL midop_ack_cycle: first ack at cycle %0d, required 35", ack_n);
        end
        checks++;
        if (bus.reg_rd_data !== 32'd0) begin
            fails++;
            $display("FAIL midop_idx2: data=%h, required 0", bus.reg_rd_data);
        end
        @(posedge clk);
        #1 bus.reg_rd_en = 1'b0;
        do_read(7'h48, d, lat);
        checks++;
        if (d !== 32'd0) begin
            fails++;
            $display("FAIL midop_idx18: data=%h, required 0", d);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        logic [31:0] want;
        int lat;
        for (int i = 0; i < 256; i++) send_inc(5'd1, 24'hFF_FFFF);
        send_inc(5'd1, 24'h0000F0);
        do_read(7'h04, d, lat);
        checks++;
        if (d !== 32'hFFFF_FFF0 || d !== model[1]) begin
            fails++;
            $display("FAIL wrap_preload: data=%h, required FFFFFFF0", d);
        end
        send_inc(5'd1, 24'h000020);
`ifdef STATS_COUNTER_SATURATE_EN
        want = 32'hFFFF_FFFF;
`else
        want = 32'h0000_0010;
`endif
        do_read(7'h04, d, lat);
        checks++;
        if (d !== want || d !== model[1]) begin
            fails++;
            $display("FAIL wrap_result: data=%h, required %h", d, want);
        end
    endtask

    initial begin
        bus.s_axis_stat_tdata = '0;
        bus.s_axis_stat_tid = '0;
        bus.s_axis_stat_tvalid = 1'b0;
        bus.reg_rd_addr = '0;
        bus.reg_rd_en = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_reset_midop();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
